// File: rtl/pipe_trace_pkg.sv
// rtl/pipe_trace_pkg.sv - shared types and helpers for the pipeline trace buffer
package pipe_trace_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

  // Default geometry; instances with other depths derive their own widths.
  localparam int TRACE_DEPTH = 16;
  localparam int PTR_W       = $clog2(TRACE_DEPTH);
  localparam int CNT_W       = $clog2(TRACE_DEPTH + 1);

  // Low bit of probe channel k on a bus of w-bit channels.
  function automatic int ch_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/pipe_trace_buffer_if.sv
// rtl/pipe_trace_buffer_if.sv - readout stream of the pipeline trace buffer
interface pipe_trace_buffer_if #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 5
);
  logic                     rd_valid;
  logic                     rd_ready;
  logic [NUM_CH*DATA_W-1:0] rd_data;
  logic                     rd_last;

  modport master (output rd_valid, output rd_data, output rd_last, input rd_ready);
  modport slave  (input rd_valid, input rd_data, input rd_last, output rd_ready);
endinterface

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - register-array trace memory, synchronous write, asynchronous read
module trace_ram #(
  parameter int WIDTH = 160,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/pipe_trace_buffer.sv
// rtl/pipe_trace_buffer.sv - triggered circular trace capture with oldest-first readout
module pipe_trace_buffer
  import pipe_trace_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_CH    = 5,
  parameter int DEPTH     = TRACE_DEPTH,
  parameter int POST_TRIG = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_CH*DATA_W-1:0]     ch_data,
  input  logic                         sample_en,
  input  logic                         arm,
  input  logic                         abort,
  input  logic [DATA_W-1:0]            trig_value,
  input  logic                         force_trig,
  pipe_trace_buffer_if.master          rd,
  output logic                         armed,
  output logic                         done,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  state_t        state, state_nxt;
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_inc;
  logic [CW-1:0] post_cnt, remaining, count_inc;
  logic          wr_en, trig, rd_hs;

  assign wr_en      = (state == ARMED || state == POST) && sample_en;
  assign trig       = (state == ARMED) && sample_en &&
                      (ch_data[ch_lo(0, DATA_W) +: DATA_W] == trig_value || force_trig);
  assign rd_hs      = rd.rd_valid && rd.rd_ready;
  assign wr_ptr_inc = wr_ptr + 1'b1;
  assign count_inc  = (count == CW'(DEPTH)) ? count : count + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (arm) state_nxt = ARMED;
        ARMED:   if (trig) state_nxt = (POST_TRIG == 0) ? DONE : POST;
        POST:    if (wr_en && post_cnt == CW'(1)) state_nxt = DONE;
        default: if (rd_hs && remaining == CW'(1)) state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    armed       = (state == ARMED) || (state == POST);
    done        = (state == DONE);
    rd.rd_valid = done && (remaining != '0);
    rd.rd_last  = done && (remaining == CW'(1));
  end

  // Entry into DONE always coincides with a store, so the readout start is
  // taken from the post-store pointer and count; a full buffer lands on wr_ptr.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      post_cnt  <= '0;
      remaining <= '0;
    end else if (abort) begin
      wr_ptr    <= '0;
      count     <= '0;
      remaining <= '0;
    end else begin
      if (state == IDLE && arm) begin
        wr_ptr <= '0;
        count  <= '0;
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr_inc;
        count  <= count_inc;
      end
      if (trig)                      post_cnt <= CW'(POST_TRIG);
      else if (state == POST && wr_en) post_cnt <= post_cnt - 1'b1;
      if (state != DONE && state_nxt == DONE) begin
        rd_ptr    <= wr_ptr_inc - PW'(count_inc);
        remaining <= count_inc;
      end else if (rd_hs) begin
        rd_ptr    <= rd_ptr + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end

  trace_ram #(
    .WIDTH(NUM_CH*DATA_W),
    .DEPTH(DEPTH)
  ) u_ram (
    .clock  (clock),
    .wr_en  (wr_en),
    .wr_addr(wr_ptr),
    .wr_data(ch_data),
    .rd_addr(rd_ptr),
    .rd_data(rd.rd_data)
  );
endmodule

// File: tb/tb_pipe_trace_buffer.sv
// tb/tb_pipe_trace_buffer.sv - self-checking bench for pipe_trace_buffer (DEPTH 16/8 instances)
module tb_pipe_trace_buffer;
  localparam int DATA_W = 32;
  localparam int NUM_CH = 5;
  localparam int W      = DATA_W * NUM_CH;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [W-1:0]      ch_data = '0;
  logic              sample_en = 1'b0, arm = 1'b0, abort = 1'b0, force_trig = 1'b0;
  logic              rd_ready = 1'b0;
  logic [DATA_W-1:0] trig_value = '0;
  logic              armed16, done16, armed8, done8;
  logic [4:0]        count16;
  logic [3:0]        count8;

  int n_pass = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  pipe_trace_buffer_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) if16 ();
  pipe_trace_buffer_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) if8 ();
  assign if16.rd_ready = rd_ready;
  assign if8.rd_ready  = rd_ready;

  pipe_trace_buffer #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(16), .POST_TRIG(8)) u16 (
    .clock(clock), .reset(reset), .ch_data(ch_data), .sample_en(sample_en), .arm(arm),
    .abort(abort), .trig_value(trig_value), .force_trig(force_trig), .rd(if16),
    .armed(armed16), .done(done16), .count(count16));

  pipe_trace_buffer #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(8), .POST_TRIG(0)) u8 (
    .clock(clock), .reset(reset), .ch_data(ch_data), .sample_en(sample_en), .arm(arm),
    .abort(abort), .trig_value(trig_value), .force_trig(force_trig), .rd(if8),
    .armed(armed8), .done(done8), .count(count8));

  // Reference model: 0 idle, 1 waiting for trigger, 2 post-trigger, 3 reading out.
  int           mode [2] = '{0, 0};
  int           left [2] = '{0, 0};
  int           mcnt [2] = '{0, 0};
  logic [W-1:0] mq [2][$];

  typedef struct {
    logic [31:0] trig;
    int          cnt16;
    logic [31:0] first16;
    int          cnt8;
    logic [31:0] first8;
  } vec_t;
  vec_t vt [4];

  task automatic check(input string nm, input int d, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, d, $time, act, exp);
    else n_pass++;
  endtask

  task automatic model_step(input int d);
    int dep;
    int pst;
    dep = (d == 0) ? 16 : 8;
    pst = (d == 0) ? 8 : 0;
    if (reset || abort) begin
      mode[d] = 0; mq[d].delete(); mcnt[d] = 0;
    end else begin
      case (mode[d])
        0: if (arm) begin mode[d] = 1; mq[d].delete(); mcnt[d] = 0; end
        1, 2: if (sample_en) begin
          mq[d].push_back(ch_data);
          if (mq[d].size() > dep) void'(mq[d].pop_front());
          mcnt[d] = mq[d].size();
          if (mode[d] == 1) begin
            if (ch_data[DATA_W-1:0] == trig_value || force_trig) begin
              if (pst == 0) mode[d] = 3;
              else begin mode[d] = 2; left[d] = pst; end
            end
          end else begin
            left[d]--;
            if (left[d] == 0) mode[d] = 3;
          end
        end
        default: if (rd_ready && mq[d].size() > 0) begin
          void'(mq[d].pop_front());
          if (mq[d].size() == 0) mode[d] = 0;
        end
      endcase
    end
  endtask

  task automatic compare(input int d, input logic rv, input logic rl, input logic [W-1:0] rdat,
                         input logic ar, input logic dn, input int cnt);
    logic ev;
    ev = (mode[d] == 3) && (mq[d].size() > 0);
    check("rd_valid", d, W'(rv), W'(ev));
    check("rd_last", d, W'(rl), W'(ev && mq[d].size() == 1));
    if (ev) check("rd_data", d, rdat, mq[d][0]);
    check("armed", d, W'(ar), W'(mode[d] == 1 || mode[d] == 2));
    check("done", d, W'(dn), W'(mode[d] == 3));
    check("count", d, W'(cnt), W'(mcnt[d]));
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step(0);
    model_step(1);
    #1;
    compare(0, if16.rd_valid, if16.rd_last, if16.rd_data, armed16, done16, int'(count16));
    compare(1, if8.rd_valid, if8.rd_last, if8.rd_data, armed8, done8, int'(count8));
  endtask

  task automatic set_ch0(input logic [31:0] v);
    ch_data = {$urandom(), $urandom(), $urandom(), $urandom(), v};
  endtask

  task automatic drain(input bit bp);
    int           k;
    logic [W-1:0] pd;
    logic         pl, stall;
    k = 0;
    while ((done16 || done8) && k < 200) begin
      pd = if16.rd_data;
      pl = if16.rd_last;
      rd_ready = bp ? ((k < 5) ? 1'b0 : k[0]) : 1'b1;
      stall = !rd_ready && if16.rd_valid;
      cycle();
      if (stall) begin
        check("stall_data", 0, if16.rd_data, pd);
        check("stall_last", 0, W'(if16.rd_last), W'(pl));
      end
      k++;
    end
    check("drain_bound", 0, W'(k < 200), W'(1));
    rd_ready = 1'b0;
  endtask

  initial begin
    int i;
    vt[0] = '{32'h40, 16, 32'h24, 8, 32'h24};
    vt[1] = '{32'h08, 11, 32'h00, 3, 32'h00};
    vt[2] = '{32'h1C, 16, 32'h00, 8, 32'h00};
    vt[3] = '{32'h20, 16, 32'h04, 8, 32'h04};

    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    check("rst_valid", 0, W'(if16.rd_valid), W'(0));
    check("rst_last", 0, W'(if16.rd_last), W'(0));
    check("rst_armed", 0, W'(armed16), W'(0));
    check("rst_done", 0, W'(done16), W'(0));
    check("rst_count", 0, W'(count16), W'(0));

    for (int r = 0; r < 4; r++) begin
      trig_value = vt[r].trig;
      rd_ready   = 1'b0;
      arm = 1'b1; cycle(); arm = 1'b0;
      sample_en = 1'b1;
      i = 0;
      while (!done16 && i < 64) begin
        set_ch0(32'(4 * i));
        cycle();
        i++;
      end
      sample_en = 1'b0;
      check("scn_done", r, W'(done16), W'(1));
      check("scn_cnt16", r, W'(count16), W'(vt[r].cnt16));
      check("scn_first16", r, W'(if16.rd_data[31:0]), W'(vt[r].first16));
      check("scn_cnt8", r, W'(count8), W'(vt[r].cnt8));
      check("scn_first8", r, W'(if8.rd_data[31:0]), W'(vt[r].first8));
      if (r == 0) begin
        arm = 1'b1; cycle(); arm = 1'b0;
        check("arm_in_done", 0, W'(done16), W'(1));
        drain(1'b1);
      end else if (r == 2) begin
        rd_ready = 1'b1;
        repeat (3) cycle();
        rd_ready = 1'b0;
        reset = 1'b1; cycle(); reset = 1'b0;
        check("midrd_rst_valid", 0, W'(if16.rd_valid), W'(0));
        check("midrd_rst_done", 0, W'(done16), W'(0));
        check("midrd_rst_count", 0, W'(count16), W'(0));
        check("midrd_rst_valid", 1, W'(if8.rd_valid), W'(0));
      end else begin
        drain(1'b0);
      end
    end

    // Sparse sampling with wrap on the depth-8 instance, forced trigger.
    trig_value = 32'hFFFF_FFFF;
    arm = 1'b1; cycle(); arm = 1'b0;
    for (int n = 1; n <= 21; n++) begin
      sample_en = 1'b1; force_trig = (n == 21); set_ch0(32'(n));
      cycle();
      sample_en = 1'b0; force_trig = 1'b0;
      cycle();
    end
    check("wrap_cnt8", 1, W'(count8), W'(8));
    check("wrap_post16", 0, W'(armed16), W'(1));
    rd_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      check("wrap_data", j, W'(if8.rd_data[31:0]), W'(14 + j));
      cycle();
    end
    rd_ready = 1'b0;
    check("wrap_idle8", 1, W'(done8), W'(0));

    abort = 1'b1; cycle(); abort = 1'b0;
    check("abort_armed", 0, W'(armed16), W'(0));
    check("abort_count", 0, W'(count16), W'(0));
    check("abort_valid", 0, W'(if16.rd_valid), W'(0));
    cycle();
    check("abort_valid2", 0, W'(if16.rd_valid), W'(0));
    arm = 1'b1; abort = 1'b1; cycle(); arm = 1'b0; abort = 1'b0;
    check("arm_abort", 0, W'(armed16), W'(0));
    check("arm_abort", 1, W'(armed8), W'(0));

    trig_value = 32'h3;
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 499) == 0);
      arm        = ($urandom_range(0, 19) == 0);
      abort      = ($urandom_range(0, 149) == 0);
      sample_en  = 1'($urandom_range(0, 1));
      force_trig = ($urandom_range(0, 39) == 0);
      rd_ready   = ($urandom_range(0, 3) != 0);
      set_ch0(32'($urandom_range(0, 15)));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pipe_trace_buffer.md
Name: pipe_trace_buffer

Overview:
- Parametrised on-chip trace capture for the pipelined CPU.
- Samples NUM_CH probe channels of DATA_W bits each cycle that sample_en is high, e.g. pc, inst, ealu, malu, walu.
- Captures into a circular buffer around a trigger: pre-trigger history plus POST_TRIG post-trigger samples.
- Streams the capture out oldest-first over a valid/ready port, so pipeline behaviour can be checked on FPGA without a simulator.

Parameters:
- DATA_W, 32, width of one probe channel
- NUM_CH, 5, number of probe channels; channel 0 is the trigger channel
- DEPTH, 16, buffer entries; power of two, ≥4
- POST_TRIG, 8, samples stored after the trigger sample; legal range 0..DEPTH-1

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high reset
- ch_data  in  NUM_CH*DATA_W  probe bus; channel k at bits [k*DATA_W +: DATA_W]
- sample_en  in  1  qualifies ch_data this cycle
- arm  in  1  one-cycle pulse; starts a capture from IDLE
- abort  in  1  one-cycle pulse; returns to IDLE from any state
- trig_value  in  DATA_W  compare value for channel 0
- force_trig  in  1  trigger regardless of compare
- rd_valid  out  1  readout entry available
- rd_ready  in  1  consumer accepts entry
- rd_data  out  NUM_CH*DATA_W  entry, same layout as ch_data
- rd_last  out  1  high with the final entry
- armed  out  1  state is ARMED or POST
- done  out  1  state is DONE
- count  out  $clog2(DEPTH+1)  valid entries held

Behaviour:
- Reset values: state IDLE; all pointers and counters 0; rd_valid, rd_last, armed, done all 0; count 0. Memory contents are not reset.
- Reset mid-capture or mid-readout discards everything.
- Four states: IDLE, ARMED, POST, DONE.
- IDLE:
  - arm moves to ARMED next cycle and clears wr_ptr and count.
  - A sample in the arm cycle is not stored.
- ARMED:
  - Each sample_en cycle writes ch_data to mem[wr_ptr]; wr_ptr increments mod DEPTH.
  - count saturates at DEPTH; the oldest entry is overwritten when full.
  - Trigger = sample_en && (ch0 == trig_value || force_trig).
  - The trigger sample is stored.
  - On trigger: if POST_TRIG == 0, go to DONE; else go to POST with post_cnt = POST_TRIG.
  - force_trig without sample_en does nothing.
- POST:
  - Each sample_en cycle stores as in ARMED and decrements post_cnt.
  - When post_cnt reaches 0 after the store, go to DONE.
  - Further trigger conditions are ignored.
- DONE:
  - rd_ptr initialises to (wr_ptr - count) mod DEPTH on entry.
  - rd_valid = 1 while the remaining-count is > 0.
  - rd_data = mem[rd_ptr], driven combinationally from the registered rd_ptr.
  - rd_data and rd_last stay stable while rd_valid && !rd_ready.
  - On a rd_valid && rd_ready handshake: rd_ptr++, remaining--.
  - rd_last = (remaining == 1).
  - The handshake on the last entry returns to IDLE next cycle.
  - count keeps the captured total until IDLE is re-entered; IDLE holds the last value until the next arm.
  - No sampling occurs in DONE.
- Priority: reset > abort > everything else.
  - abort in any state: IDLE next cycle, rd_valid dropped immediately after the edge, count 0.
  - arm outside IDLE is ignored.
  - arm and abort in the same cycle: abort wins.
- Trigger at fewer than DEPTH pre-samples is legal; the capture simply holds fewer entries.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally.
  - The readout start pointer uses modular subtraction.
  - count == DEPTH must yield rd_ptr == wr_ptr.
- Single-port write and asynchronous read; memory is a register array.
- No write and read occur in the same state.

Decomposition:
- Package pipe_trace_pkg holds:
  - state enum {IDLE, ARMED, POST, DONE}
  - a localparam for pointer width, $clog2(DEPTH)
  - a localparam for count width, $clog2(DEPTH+1)
  - the channel slice helper function
- One natural sub-module, trace_ram: DEPTH x (NUM_CH*DATA_W), one synchronous write port, one asynchronous read port.
- The FSM and pointer logic stay in pipe_trace_buffer.

Test Plan:
1. Basic capture, DEPTH=16, POST_TRIG=8.
   - Stimulus: arm, then ch0 = 0,4,8,… with sample_en every cycle, trig_value=0x40.
   - Required: done after sample 0x60; count=16; readout ch0 = 0x24..0x60 ascending; rd_last on 0x60.
2. Early trigger.
   - Stimulus: arm, 3 samples 0x0,0x4,0x8, trig_value=0x8.
   - Required: after 8 more samples, count=11; first entry read is 0x0.
3. Backpressure.
   - Stimulus: during readout, hold rd_ready low 5 cycles, then toggle it every other cycle.
   - Required: rd_data and rd_last stable while stalled; every entry delivered exactly once, in order.
4. Wrap and sparse sampling.
   - Stimulus: DEPTH=8, POST_TRIG=0, sample_en toggling, 21 samples, force_trig on the 21st sampled cycle.
   - Required: count=8; readout = samples 14..21; rd_ptr wraps correctly.
5. Abort and ignored arm.
   - Abort mid-POST: IDLE next cycle, count=0, rd_valid stays 0.
   - arm pulsed in DONE: ignored.
   - Simultaneous arm+abort in IDLE: stays IDLE.
6. Reset mid-readout.
   - Stimulus: assert reset after 3 handshakes.
   - Required: all outputs return to reset values next edge; a fresh arm/trigger capture then reads back correctly.
